// File: rtl/ulpb_ctrl.sv
// Ring-head controller for the ulpb serial bus: owns the bus clock, closes the ring,
// detects arbitration, forwards ring data and ends every transaction with the reset/idle signature.
module ulpb_ctrl #(
  parameter int unsigned HALF_PERIOD  = 4,
  parameter int unsigned QUIET_CYCLES = 8,
  parameter int unsigned MAX_CYCLES   = 1024,
  parameter logic [2:0]  RST_PATTERN  = 3'b010,
  parameter logic [4:0]  IDLE_PATTERN = 5'b11011
) (
  input  logic CLK,
  input  logic RESET,
  input  logic DIN,
  output logic DOUT,
  output logic CLK_OUT,
  input  logic RESET_REQ,
  output logic BUS_BUSY,
  output logic TIMEOUT,
  input  logic TIMEOUT_ACK
);

  localparam int unsigned PH_W   = $clog2(2 * HALF_PERIOD);
  localparam int unsigned HOLD_W = $clog2(4 * HALF_PERIOD);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_RISE   = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(HALF_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(4 * HALF_PERIOD - 1);
  localparam logic [15:0]       CYC_MAX   = 16'(MAX_CYCLES);
  localparam logic [15:0]       QUIET_MAX = 16'(QUIET_CYCLES);
  localparam logic [7:0]        SIG       = {RST_PATTERN, IDLE_PATTERN};

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARB  = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_RST  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  logic [2:0]        state, state_nxt;
  logic              din_q;
  logic              idle_low, idle_low_nxt;
  logic [PH_W-1:0]   ph_cnt, ph_nxt;
  logic [15:0]       cycle_cnt, cycle_cnt_nxt;
  logic [15:0]       quiet_cnt, quiet_cnt_nxt;
  logic              last_din, last_din_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic              sig_active, sig_active_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              dout_nxt, clk_out_nxt, busy_nxt, timeout_nxt;

  logic [PH_W-1:0]   ph_adv;
  logic              clk_adv;
  logic              at_fall, at_rise;
  logic [15:0]       cyc_inc, quiet_upd;

  // Phase bookkeeping shared by every clocked state.
  always_comb begin
    ph_adv    = (ph_cnt == PH_LAST) ? '0 : ph_cnt + PH_W'(1);
    clk_adv   = (ph_adv >= PH_HIGH);
    at_fall   = (ph_cnt == PH_LAST);
    at_rise   = (ph_cnt == PH_RISE);
    cyc_inc   = (cycle_cnt == 16'hFFFF) ? cycle_cnt : cycle_cnt + 16'd1;
    quiet_upd = (din_q != last_din) ? 16'd0 : quiet_cnt + 16'd1;
  end

  always_comb begin
    state_nxt      = state;
    idle_low_nxt   = idle_low;
    ph_nxt         = ph_cnt;
    cycle_cnt_nxt  = cycle_cnt;
    quiet_cnt_nxt  = quiet_cnt;
    last_din_nxt   = last_din;
    bit_idx_nxt    = bit_idx;
    sig_active_nxt = sig_active;
    hold_cnt_nxt   = hold_cnt;
    dout_nxt       = DOUT;
    clk_out_nxt    = CLK_OUT;
    busy_nxt       = BUS_BUSY;
    timeout_nxt    = TIMEOUT_ACK ? 1'b0 : TIMEOUT;

    case (state)
      ST_IDLE: begin
        clk_out_nxt = 1'b1;
        dout_nxt    = 1'b1;
        busy_nxt    = 1'b0;
        if (!din_q) begin
          if (idle_low) begin
            // Park the phase at the last high cycle so the next edge is the first fall.
            state_nxt    = ST_ARB;
            busy_nxt     = 1'b1;
            ph_nxt       = PH_LAST;
            idle_low_nxt = 1'b0;
          end else begin
            idle_low_nxt = 1'b1;
          end
        end else begin
          idle_low_nxt = 1'b0;
        end
      end

      ST_ARB: begin
        ph_nxt      = ph_adv;
        clk_out_nxt = clk_adv;
        if (at_rise) begin
          cycle_cnt_nxt = cyc_inc;
          last_din_nxt  = din_q;
        end
        if (at_fall && (cycle_cnt != 16'd0)) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        ph_nxt      = ph_adv;
        clk_out_nxt = clk_adv;
        dout_nxt    = din_q;
        if (at_rise) begin
          cycle_cnt_nxt = cyc_inc;
          quiet_cnt_nxt = quiet_upd;
          last_din_nxt  = din_q;
          if (RESET_REQ || (quiet_upd == QUIET_MAX) || (cyc_inc == CYC_MAX)) begin
            state_nxt      = ST_RST;
            bit_idx_nxt    = 3'd0;
            sig_active_nxt = 1'b0;
            if (!RESET_REQ && (quiet_upd != QUIET_MAX)) begin
              timeout_nxt = 1'b1;
            end
          end
        end
      end

      ST_RST: begin
        ph_nxt      = ph_adv;
        clk_out_nxt = clk_adv;
        if (at_fall) begin
          // A wrapped bit index after the first drive means all eight bits are out.
          if (sig_active && (bit_idx == 3'd0)) begin
            state_nxt    = ST_HOLD;
            clk_out_nxt  = 1'b1;
            dout_nxt     = 1'b1;
            hold_cnt_nxt = '0;
          end else begin
            dout_nxt       = SIG[3'd7 - bit_idx];
            bit_idx_nxt    = bit_idx + 3'd1;
            sig_active_nxt = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        clk_out_nxt = 1'b1;
        dout_nxt    = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt      = ST_IDLE;
          busy_nxt       = 1'b0;
          idle_low_nxt   = 1'b0;
          ph_nxt         = '0;
          cycle_cnt_nxt  = 16'd0;
          quiet_cnt_nxt  = 16'd0;
          last_din_nxt   = 1'b0;
          bit_idx_nxt    = 3'd0;
          sig_active_nxt = 1'b0;
          hold_cnt_nxt   = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        clk_out_nxt = 1'b1;
        dout_nxt    = 1'b1;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      din_q      <= 1'b1;
      idle_low   <= 1'b0;
      ph_cnt     <= '0;
      cycle_cnt  <= 16'd0;
      quiet_cnt  <= 16'd0;
      last_din   <= 1'b0;
      bit_idx    <= 3'd0;
      sig_active <= 1'b0;
      hold_cnt   <= '0;
      DOUT       <= 1'b1;
      CLK_OUT    <= 1'b1;
      BUS_BUSY   <= 1'b0;
      TIMEOUT    <= 1'b0;
    end else begin
      state      <= state_nxt;
      din_q      <= DIN;
      idle_low   <= idle_low_nxt;
      ph_cnt     <= ph_nxt;
      cycle_cnt  <= cycle_cnt_nxt;
      quiet_cnt  <= quiet_cnt_nxt;
      last_din   <= last_din_nxt;
      bit_idx    <= bit_idx_nxt;
      sig_active <= sig_active_nxt;
      hold_cnt   <= hold_cnt_nxt;
      DOUT       <= dout_nxt;
      CLK_OUT    <= clk_out_nxt;
      BUS_BUSY   <= busy_nxt;
      TIMEOUT    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_ulpb_ctrl.sv
// Bench for ulpb_ctrl: directed and randomized transactions compared against a
// bus-cycle level model of arbitration, forwarding, exit priority and signature.
module tb_ulpb_ctrl;

  localparam int HP    = 4;
  localparam int QUIET = 8;
  localparam int MAXC  = 20;
  localparam int HOLDN = 4 * HP;

  logic CLK = 1'b0;
  logic RESET, DIN, DOUT, CLK_OUT, RESET_REQ, BUS_BUSY, TIMEOUT, TIMEOUT_ACK;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_tmo  = 1'b0;
  bit d [1:40];
  logic [7:0] sig_v;
  logic [3:0] pat_v;

  ulpb_ctrl #(
    .HALF_PERIOD (HP),
    .QUIET_CYCLES(QUIET),
    .MAX_CYCLES  (MAXC),
    .RST_PATTERN (3'b010),
    .IDLE_PATTERN(5'b11011)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DIN        (DIN),
    .DOUT       (DOUT),
    .CLK_OUT    (CLK_OUT),
    .RESET_REQ  (RESET_REQ),
    .BUS_BUSY   (BUS_BUSY),
    .TIMEOUT    (TIMEOUT),
    .TIMEOUT_ACK(TIMEOUT_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Exit bus cycle and timeout flag from the per-bus-cycle ring values d[].
  task automatic model(input int req_at, output int e, output bit t);
    int q;
    q = 0;
    e = 0;
    t = 1'b0;
    for (int n = 2; n <= 40; n++) begin
      q = (d[n] != d[n-1]) ? 0 : q + 1;
      if (req_at == n) begin e = n; t = 1'b0; return; end
      if (q == QUIET)  begin e = n; return; end
      if (n == MAXC)   begin e = n; t = 1'b1; return; end
    end
  endtask

  task automatic idle_check(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      step();
      if (i % 8 == 7) begin
        chk({tag, "_busy"}, 32'(BUS_BUSY), 32'd0);
        chk({tag, "_clk"}, 32'(CLK_OUT), 32'd1);
        chk({tag, "_dout"}, 32'(DOUT), 32'd1);
        chk({tag, "_tmo"}, 32'(TIMEOUT), 32'(exp_tmo));
      end
    end
  endtask

  task automatic ack_pulse();
    TIMEOUT_ACK = 1'b1;
    step();
    TIMEOUT_ACK = 1'b0;
    exp_tmo = 1'b0;
    chk("ack_clear", 32'(TIMEOUT), 32'd0);
  endtask

  task automatic run_txn(input string tag, input int req_at, input bit ack_exit, input bit rst_sig3);
    int e, n, ph, k_h, total;
    bit t;
    model(req_at, e, t);
    k_h   = 1 + (e + 8) * 2 * HP;
    total = k_h + HOLDN;
    DIN = 1'b0;
    step(); chk({tag, "_arb_w1"}, 32'(BUS_BUSY), 32'd0);
    step(); chk({tag, "_arb_w2"}, 32'(BUS_BUSY), 32'd0);
    step(); chk({tag, "_arb_in"}, 32'(BUS_BUSY), 32'd1);
    chk({tag, "_arb_clk"}, 32'(CLK_OUT), 32'd1);
    for (int k = 1; k <= total; k++) begin
      step();
      n  = (k - 1) / (2 * HP) + 1;
      ph = (k - 1) % (2 * HP);
      if (k < k_h) begin
        if (ph == 0 && n <= e) DIN = d[n];
        if (ph == 0 && n == e + 1) DIN = 1'b1;
        if (n == req_at && ph == 1) RESET_REQ = 1'b1;
        if (ph == HP) RESET_REQ = 1'b0;
        chk({tag, "_clk"}, 32'(CLK_OUT), 32'(ph >= HP));
        if (ph == HP) begin
          chk({tag, "_busy"}, 32'(BUS_BUSY), 32'd1);
          if (n == 1)
            chk({tag, "_dout_arb"}, 32'(DOUT), 32'd1);
          else if (n <= e)
            chk({tag, "_dout_fwd"}, 32'(DOUT), 32'(d[n]));
          else
            chk({tag, "_dout_sig"}, 32'(DOUT), 32'(sig_v[7 - (n - e - 1)]));
        end
        if (n == e && ph == HP - 1) begin
          chk({tag, "_tmo_pre"}, 32'(TIMEOUT), 32'(exp_tmo));
          if (ack_exit) TIMEOUT_ACK = 1'b1;
        end
        if (n == e && ph == HP) begin
          TIMEOUT_ACK = 1'b0;
          if (t) exp_tmo = 1'b1;
          else if (ack_exit) exp_tmo = 1'b0;
          chk({tag, "_tmo_exit"}, 32'(TIMEOUT), 32'(exp_tmo));
        end
        if (rst_sig3 && n == e + 3 && ph == HP) begin
          #2 RESET = 1'b1;
          #1;
          exp_tmo = 1'b0;
          DIN = 1'b1;
          RESET_REQ = 1'b0;
          chk({tag, "_arst_clk"}, 32'(CLK_OUT), 32'd1);
          chk({tag, "_arst_dout"}, 32'(DOUT), 32'd1);
          chk({tag, "_arst_busy"}, 32'(BUS_BUSY), 32'd0);
          chk({tag, "_arst_tmo"}, 32'(TIMEOUT), 32'd0);
          @(negedge CLK);
          RESET = 1'b0;
          step();
          return;
        end
      end else if (k < total) begin
        if (k == k_h || k == total - 1) begin
          chk({tag, "_hold_clk"}, 32'(CLK_OUT), 32'd1);
          chk({tag, "_hold_dout"}, 32'(DOUT), 32'd1);
          chk({tag, "_hold_busy"}, 32'(BUS_BUSY), 32'd1);
        end
      end else begin
        chk({tag, "_idle_busy"}, 32'(BUS_BUSY), 32'd0);
        chk({tag, "_idle_clk"}, 32'(CLK_OUT), 32'd1);
      end
    end
  endtask

  initial begin
    int brk;
    sig_v = 8'b01011011;
    pat_v = 4'b1011;
    RESET = 1'b1; DIN = 1'b1; RESET_REQ = 1'b0; TIMEOUT_ACK = 1'b0;
    #1;
    chk("rst_clk", 32'(CLK_OUT), 32'd1);
    chk("rst_dout", 32'(DOUT), 32'd1);
    chk("rst_busy", 32'(BUS_BUSY), 32'd0);
    chk("rst_tmo", 32'(TIMEOUT), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK) RESET = 1'b0;
    step();

    idle_check(100, "idle");
    RESET_REQ = 1'b1;
    idle_check(40, "idle_req");
    RESET_REQ = 1'b0;
    step();

    // Forwarding of 1,0,1,1 runs until the 20-cycle timeout.
    for (int n = 1; n <= 40; n++) d[n] = pat_v[3 - ((n - 1) % 4)];
    run_txn("fwd_tmo", 0, 1'b0, 1'b0);
    idle_check(24, "tmo_sticky");
    ack_pulse();

    // Normal completion after a constant ring.
    for (int n = 1; n <= 40; n++) d[n] = (n == 2) ? 1'b0 : 1'b1;
    run_txn("done", 0, 1'b0, 1'b0);
    chk("done_tmo", 32'(TIMEOUT), 32'd0);

    // Request, quiet and max all coincide at cycle 20: request wins, no timeout.
    for (int n = 1; n <= 40; n++) d[n] = (n <= 12) ? 1'(n % 2) : 1'b0;
    run_txn("prio", 20, 1'b0, 1'b0);
    chk("prio_tmo", 32'(TIMEOUT), 32'd0);

    for (int r = 0; r < 6; r++) begin
      brk = $urandom_range(2, 22);
      d[1] = 1'($urandom_range(0, 1));
      for (int n = 2; n <= 40; n++) d[n] = (n < brk) ? 1'($urandom_range(0, 1)) : d[n-1];
      run_txn($sformatf("rnd%0d", r), $urandom_range(2, 30), 1'b0, 1'b0);
      if (exp_tmo) ack_pulse();
    end

    // Acknowledge on the very edge of a new timeout: set wins.
    for (int n = 1; n <= 40; n++) d[n] = 1'(n % 2);
    run_txn("tmo_a", 0, 1'b0, 1'b0);
    run_txn("tmo_ack_same", 0, 1'b1, 1'b0);
    idle_check(16, "tmo_kept");
    ack_pulse();

    run_txn("arst", 0, 1'b0, 1'b1);
    idle_check(40, "post_arst");
    for (int n = 1; n <= 40; n++) d[n] = (n == 2) ? 1'b0 : 1'b1;
    run_txn("recover", 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
